// File: rtl/hyperbus_wb_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-hyperbus FIFO bridge.
package hyperbus_wb_bridge_pkg;

    // Byte address to hyperbus 16-bit word address.
    localparam int ADDR_SHIFT = 1;
    localparam int DISC_W     = 2;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        RD_WAIT  = 5'b00010,
        RMW_WAIT = 5'b00100,
        WR_WAIT  = 5'b01000,
        ACK      = 5'b10000
    } state_e;

endpackage

// File: rtl/hyperbus_byte_merge.sv
// Byte-lane merge: lanes with sel set take new data, the rest keep old data.
module hyperbus_byte_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [DATA_WIDTH-1:0]   new_i,
    input  logic [DATA_WIDTH-1:0]   old_i,
    output logic [DATA_WIDTH-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
            if (sel_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave driving the hyperbus FIFO command/data path,
// with read-modify-write for sub-word writes, wait timeout and stale-read discard.
module hyperbus_wb_bridge
    import hyperbus_wb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    fifo_rrq,
    output logic                    fifo_wrq,
    output logic [ADDR_WIDTH-1:0]   fifo_adr_o,
    output logic [DATA_WIDTH-1:0]   fifo_tx_dat_o,
    input  logic                    fifo_tx_ready,
    input  logic [DATA_WIDTH-1:0]   fifo_rx_dat_i,
    input  logic                    fifo_rx_valid
);

    localparam int          TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_e                  state_q, state_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [DISC_W-1:0]       disc_q, disc_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    rrq_q, rrq_d, wrq_q, wrq_d;
    logic                    ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]   merged;
    logic [ADDR_WIDTH-1:0]   word_adr;
    logic                    req, timeout_hit, drop_read;

    hyperbus_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .sel_i    (wb_sel_i),
        .new_i    (wb_dat_i),
        .old_i    (fifo_rx_dat_i),
        .merged_o (merged)
    );

    always_comb begin
        word_adr    = wb_adr_i >> ADDR_SHIFT;
        word_adr[0] = 1'b0;
    end

    assign req         = wb_cyc_i & wb_stb_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TW'(TLIM));

    // Timeouts route through ACK (with err) so IDLE never re-samples a held strobe.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        disc_d    = disc_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        rrq_d     = 1'b0;
        wrq_d     = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        drop_read = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!wb_we_i) begin
                        if (disc_q == '0) begin
                            adr_d   = word_adr;
                            rrq_d   = 1'b1;
                            tcnt_d  = '0;
                            state_d = RD_WAIT;
                        end
                    end else if (wb_sel_i == '1) begin
                        adr_d   = word_adr;
                        wdat_d  = wb_dat_i;
                        tcnt_d  = '0;
                        state_d = WR_WAIT;
                    end else if (wb_sel_i == '0) begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else if (disc_q == '0) begin
                        adr_d   = word_adr;
                        rrq_d   = 1'b1;
                        tcnt_d  = '0;
                        state_d = RMW_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (fifo_rx_valid) begin
                    if (wb_cyc_i) begin
                        rdat_d  = fifo_rx_dat_i;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!wb_cyc_i) begin
                    drop_read = 1'b1;
                    state_d   = IDLE;
                end else if (timeout_hit) begin
                    drop_read = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ACK;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RMW_WAIT: begin
                if (fifo_rx_valid) begin
                    if (wb_cyc_i) begin
                        wdat_d  = merged;
                        tcnt_d  = '0;
                        state_d = WR_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!wb_cyc_i) begin
                    drop_read = 1'b1;
                    state_d   = IDLE;
                end else if (timeout_hit) begin
                    drop_read = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ACK;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WR_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (fifo_tx_ready) begin
                    wrq_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Wait states are only entered with disc_q == 0, so increment and decrement never collide.
        if (drop_read) begin
            if (disc_q != '1) disc_d = disc_q + 1'b1;
        end else if (fifo_rx_valid && (disc_q != '0)) begin
            disc_d = disc_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            disc_q  <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            rrq_q   <= 1'b0;
            wrq_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            disc_q  <= disc_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            rrq_q   <= rrq_d;
            wrq_q   <= wrq_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign wb_dat_o      = rdat_q;
    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;
    assign fifo_rrq      = rrq_q;
    assign fifo_wrq      = wrq_q;
    assign fifo_adr_o    = adr_q;
    assign fifo_tx_dat_o = wdat_q;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed bench: table of single WB transactions plus hand sequences for
// timeout, discard, abort, write stall and mid-operation reset.
module tb_hyperbus_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i, wb_dat_i, fifo_rx_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, fifo_tx_ready, fifo_rx_valid;

    logic [31:0] dat_o, fadr, tx_dat, dat_o_l, fadr_l, tx_dat_l;
    logic        ack, err, rrq, wrq, ack_l, err_l, rrq_l, wrq_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hyperbus_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
        .fifo_rrq(rrq), .fifo_wrq(wrq), .fifo_adr_o(fadr), .fifo_tx_dat_o(tx_dat),
        .fifo_tx_ready(fifo_tx_ready), .fifo_rx_dat_i(fifo_rx_dat_i), .fifo_rx_valid(fifo_rx_valid)
    );

    // Long-timeout instance for the 20-cycle write stall.
    hyperbus_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(64)) dut_l (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(dat_o_l), .wb_ack_o(ack_l), .wb_err_o(err_l),
        .fifo_rrq(rrq_l), .fifo_wrq(wrq_l), .fifo_adr_o(fadr_l), .fifo_tx_dat_o(tx_dat_l),
        .fifo_tx_ready(fifo_tx_ready), .fifo_rx_dat_i(fifo_rx_dat_i), .fifo_rx_valid(fifo_rx_valid)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] rx;
        int          rx_delay;
        logic [31:0] exp_adr;
        logic [31:0] exp_data;
        logic        exp_rrq;
        logic        exp_wrq;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] last_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic rx_pulse(input logic [31:0] d);
        fifo_rx_dat_i = d;
        fifo_rx_valid = 1'b1;
        tick();
        fifo_rx_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int viol;
        start(v.we, v.adr, v.wdat, v.sel);
        tick();
        chk($sformatf("v%0d_rrq", idx), rrq, v.exp_rrq);
        if (v.exp_rrq) begin
            chk($sformatf("v%0d_rd_adr", idx), fadr, v.exp_adr);
            viol = 0;
            for (int i = 0; i < v.rx_delay; i++) begin
                tick();
                if (ack || err || wrq || rrq) viol++;
            end
            chk($sformatf("v%0d_wait_quiet", idx), viol, 0);
            rx_pulse(v.rx);
            if (!v.we) begin
                chk($sformatf("v%0d_rd_ack", idx), ack, 1);
                chk($sformatf("v%0d_rd_data", idx), dat_o, v.exp_data);
                last_rd = v.exp_data;
            end else begin
                chk($sformatf("v%0d_rmw_no_early_wrq", idx), wrq | ack, 0);
                tick();
            end
        end else if (v.exp_wrq) begin
            chk($sformatf("v%0d_no_early_wrq", idx), wrq | ack, 0);
            tick();
        end
        if (v.we) begin
            chk($sformatf("v%0d_wr_ack", idx), ack, 1);
            chk($sformatf("v%0d_wrq", idx), wrq, v.exp_wrq);
            if (v.exp_wrq) begin
                chk($sformatf("v%0d_wr_adr", idx), fadr, v.exp_adr);
                chk($sformatf("v%0d_wr_data", idx), tx_dat, v.exp_data);
            end
            chk($sformatf("v%0d_dat_o_held", idx), dat_o, last_rd);
        end
        bus_idle();
        tick();
        chk($sformatf("v%0d_ack_single", idx), ack | wrq | rrq, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;

        //        we    adr           wdat          sel      rx            dly exp_adr       exp_data      rrq   wrq
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'hF,    32'hDEADBEEF, 5, 32'h0000_0080, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0200, 32'h12345678,  4'hF,    32'h0,        0, 32'h0000_0100, 32'h12345678, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0300, 32'h0000AB00,  4'b0010, 32'h11223344, 2, 32'h0000_0180, 32'h1122AB44, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0404, 32'hAABBCCDD,  4'b1001, 32'h01020304, 0, 32'h0000_0202, 32'hAA0203DD, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0106, 32'h0,         4'hF,    32'h0BADF00D, 1, 32'h0000_0082, 32'h0BADF00D, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0050, 32'hFFFFFFFF,  4'b0000, 32'h0,        0, 32'h0,         32'h0,        1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h99887766,  4'b1100, 32'h00000000, 3, 32'h7FFF_FFFE, 32'h99880000, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'h0000_0200, 32'h0,         4'hF,    32'hFFFFFFFF, 0, 32'h0000_0100, 32'hFFFFFFFF, 1'b1, 1'b0};

        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        fifo_rx_dat_i = '0; fifo_rx_valid = 1'b0; fifo_tx_ready = 1'b1;
        bus_idle();
        last_rd = '0;
        tick(); tick();
        chk("reset_outputs", {ack, err, rrq, wrq, ack_l, err_l, rrq_l, wrq_l}, 0);
        chk("reset_buses", {dat_o, fadr, tx_dat} == '0, 1);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Timeout on a read; the late return must be discarded.
        start(1'b0, 32'h40, 32'h0, 4'hF);
        tick();
        chk("to_rrq", rrq, 1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (err || ack) begin
                n = i;
                break;
            end
        end
        chk("to_latency", n, 8);
        chk("to_err", err, 1);
        chk("to_no_ack", ack, 0);
        bus_idle();
        tick();
        chk("to_err_single", err, 0);
        rx_pulse(32'h0000CAFE);
        chk("stale_no_ack", ack, 0);
        chk("stale_dat_o_held", dat_o, last_rd);
        start(1'b0, 32'h44, 32'h0, 4'hF);
        tick();
        chk("post_discard_rrq", rrq, 1);
        chk("post_discard_adr", fadr, 32'h22);
        tick();
        rx_pulse(32'h00005555);
        chk("post_discard_ack", ack, 1);
        chk("post_discard_data", dat_o, 32'h5555);
        last_rd = 32'h5555;
        bus_idle();
        tick();

        // rx_valid coinciding with timeout expiry: data wins.
        start(1'b0, 32'h48, 32'h0, 4'hF);
        tick();
        chk("race_rrq", rrq, 1);
        for (int i = 0; i < 7; i++) tick();
        rx_pulse(32'h77770001);
        chk("race_ack", ack, 1);
        chk("race_no_err", err, 0);
        chk("race_data", dat_o, 32'h77770001);
        last_rd = 32'h77770001;
        bus_idle();
        tick();

        // cyc drop in RD_WAIT: next read withheld until the stale return is consumed.
        start(1'b0, 32'h80, 32'h0, 4'hF);
        tick();
        chk("abort_rrq", rrq, 1);
        tick(); tick();
        bus_idle();
        tick();
        chk("abort_quiet", ack | err, 0);
        start(1'b0, 32'h84, 32'h0, 4'hF);
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rrq) viol++;
        end
        chk("rrq_withheld", viol, 0);
        rx_pulse(32'h00001111);
        chk("abort_stale_no_ack", ack, 0);
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            if (rrq) begin
                n = i;
                break;
            end
            tick();
        end
        chk("rrq_released", n != 0, 1);
        chk("released_adr", fadr, 32'h42);
        rx_pulse(32'h00002222);
        chk("released_ack", ack, 1);
        chk("released_data", dat_o, 32'h2222);
        last_rd = 32'h2222;
        bus_idle();
        tick();

        // rx_valid together with cyc drop: data dropped, no discard debt.
        start(1'b0, 32'h90, 32'h0, 4'hF);
        tick();
        chk("drop_rx_rrq", rrq, 1);
        bus_idle();
        rx_pulse(32'h00003333);
        chk("drop_rx_no_ack", ack, 0);
        chk("drop_rx_dat_o", dat_o, last_rd);
        start(1'b0, 32'h94, 32'h0, 4'hF);
        tick();
        chk("drop_rx_next_rrq", rrq, 1);
        rx_pulse(32'h00004444);
        chk("drop_rx_next_data", dat_o, 32'h4444);
        bus_idle();
        tick();

        // Write stall on the long-timeout instance, then reset during the issue pulse.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fifo_tx_ready = 1'b0;
        start(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wrq_l || ack_l || err_l) viol++;
        end
        chk("stall_quiet", viol, 0);
        fifo_tx_ready = 1'b1;
        tick();
        chk("stall_wrq", wrq_l, 1);
        chk("stall_ack", ack_l, 1);
        chk("stall_adr", fadr_l, 32'h8);
        chk("stall_data", tx_dat_l, 32'hA5A5A5A5);
        rst = 1'b1;
        #1;
        chk("midrst_pulses", {wrq_l, ack_l, rrq_l, err_l}, 0);
        chk("midrst_buses", {fadr_l, tx_dat_l, dat_o_l} == '0, 1);
        bus_idle();
        tick();
        rst = 1'b0;
        tick();

        // cyc drop in WR_WAIT: no write issued afterwards.
        fifo_tx_ready = 1'b0;
        start(1'b1, 32'h20, 32'h0F0F0F0F, 4'hF);
        tick(); tick();
        bus_idle();
        fifo_tx_ready = 1'b1;
        viol = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wrq_l || ack_l || err_l) viol++;
        end
        chk("wr_abort_no_wrq", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
